fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/core_pkg.sv | 19 +
 rtl/sync_fifo.sv | 54 +++++
 rtl/fetch_queue.sv | 113 +++++++++++
 tb/tb_fetch_queue.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core types: fetch widths, reset PC and the queue entry layout.
package core_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h8000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fq_entry_t;

  // Fetch addresses are always word aligned.
  function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous clear. Pointers carry one extra bit so
// that full and empty never alias. Storage is rounded up to a power of two,
// so DEPTH itself need not be one. Push while full is accepted only together
// with a pop.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam int SLOTS = 1 << AW;

  logic [WIDTH-1:0] mem [SLOTS];
  logic [AW:0]      wptr, rptr;
  logic             do_push, do_pop;

  assign count   = wptr - rptr;
  assign empty   = (wptr == rptr);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr[AW-1:0]];

  // Pointer update; clear wins over any push or pop in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (clr) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage write; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues word-aligned imem requests, tags them
// with their PC, and queues in-order responses for decode. Queue space is
// reserved at request time so responses never need backpressure. A redirect
// flushes the queue and discards every response still in flight.
// DEPTH must be a power of two >= 2; 1 <= MAX_OUTST <= DEPTH.
module fetch_queue
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter int          DEPTH     = 4,
  parameter int          MAX_OUTST = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc
);

  localparam int QCW = $clog2(DEPTH) + 1;
  localparam int TCW = ((MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1) + 1;

  logic [31:0]    fetch_pc;
  logic [TCW-1:0] drop_cnt;
  logic [TCW-1:0] outst;
  logic [QCW-1:0] q_count;
  logic           q_full, q_empty, tag_full, tag_empty;
  logic [31:0]    tag_pc;
  fq_entry_t      q_wdata, q_head;
  logic           req_fire, q_push, q_pop;
  logic [31:0]    occ_w, outst_w;

  assign occ_w   = 32'(q_count);
  assign outst_w = 32'(outst);

  // Reserved slots (queued + in flight) must leave room; gated by reset so
  // the port is quiet while rst_n is low.
  assign imem_req_valid = rst_n && !redirect_valid &&
                          ((occ_w + outst_w) < 32'(DEPTH)) &&
                          (outst_w < 32'(MAX_OUTST));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses during a redirect or while drops are pending never enter.
  assign q_push  = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
  assign q_pop   = dec_valid && dec_ready && !redirect_valid;
  assign q_wdata = '{pc: tag_pc, instr: imem_rsp_data};

  assign dec_valid = !q_empty;
  assign dec_instr = dec_valid ? q_head.instr : '0;
  assign dec_pc    = dec_valid ? q_head.pc    : '0;

  // Request PCs in issue order; occupancy doubles as the outstanding count.
  sync_fifo #(.WIDTH(32), .DEPTH(MAX_OUTST)) u_tag (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .push  (req_fire),
    .wdata (fetch_pc),
    .pop   (imem_rsp_valid),
    .rdata (tag_pc),
    .full  (tag_full),
    .empty (tag_empty),
    .count (outst)
  );

  sync_fifo #(.WIDTH($bits(fq_entry_t)), .DEPTH(DEPTH)) u_iq (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (redirect_valid),
    .push  (q_push),
    .wdata (q_wdata),
    .pop   (q_pop),
    .rdata (q_head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  // Fetch PC: redirect target takes priority, else advance on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              fetch_pc <= RESET_PC;
    else if (redirect_valid) fetch_pc <= pc_align(redirect_pc);
    else if (req_fire)       fetch_pc <= fetch_pc + 32'd4;
  end

  // Drop counter: on redirect, everything still in flight after this cycle's
  // response (which is itself discarded) must be thrown away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      drop_cnt <= '0;
    else if (redirect_valid)
      drop_cnt <= outst - TCW'(imem_rsp_valid);
    else if (imem_rsp_valid && (drop_cnt != '0))
      drop_cnt <= drop_cnt - 1'b1;
  end

  a_rsp_needs_outst: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> !tag_empty);
  a_no_tag_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    req_fire |-> !tag_full);
  a_no_q_overflow:   assert property (@(posedge clk) disable iff (!rst_n)
    q_push |-> (!q_full || q_pop));

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a 1-cycle in-order imem model.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  fetch_queue dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] infl_addr [$];
  int          infl_cyc  [$];
  int          cyc;
  bit          rsp_en;
  logic [31:0] exp_req, exp_pc;
  int          acc_cnt, pop_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] f_instr(input logic [31:0] pc);
    return pc ^ 32'h1357_9BDF;
  endfunction

  // imem: answer the oldest accepted request one cycle after acceptance
  task automatic drive_rsp();
    logic [31:0] a;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (rsp_en && infl_addr.size() > 0 && (cyc - infl_cyc[0]) >= 1) begin
      a = infl_addr.pop_front();
      void'(infl_cyc.pop_front());
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = f_instr(a);
    end
  endtask

  // Account for the current (settled) cycle, then advance to the next one.
  task automatic step();
    if (imem_req_valid && imem_req_ready) begin
      chk("req_addr", imem_req_addr, exp_req);
      exp_req = exp_req + 32'd4;
      infl_addr.push_back(imem_req_addr);
      infl_cyc.push_back(cyc);
      acc_cnt++;
    end
    if (dec_valid && dec_ready && !redirect_valid) begin
      chk("pop_pc", dec_pc, exp_pc);
      chk("pop_instr", dec_instr, f_instr(exp_pc));
      exp_pc = exp_pc + 32'd4;
      pop_cnt++;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    redirect_valid = 1'b0;
    drive_rsp();
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic rsp_now();
    rsp_en = 1'b1;
    drive_rsp();
    #1;
  endtask

  // Reset DUT and imem together; release away from the clock edge.
  task automatic do_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    infl_addr.delete();
    infl_cyc.delete();
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    cyc     = 1;
    rsp_en  = 1'b1;
    exp_req = RST_PC;
    exp_pc  = RST_PC;
    acc_cnt = 0;
    pop_cnt = 0;
    drive_rsp();
    #1;
  endtask

  initial begin
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    dec_ready = 1'b1; rsp_en = 1'b1; cyc = 0;
    exp_req = RST_PC; exp_pc = RST_PC; acc_cnt = 0; pop_cnt = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 0);
    chk("rst_req_addr", imem_req_addr, RST_PC);
    chk("rst_dec_valid", 32'(dec_valid), 0);
    chk("rst_dec_instr", dec_instr, 0);
    chk("rst_dec_pc", dec_pc, 0);

    // Steady flow after reset: first request in cycle 1, dec_valid at cycle 3
    do_reset();
    chk("c1_req_valid", 32'(imem_req_valid), 1);
    chk("c1_dec_valid", 32'(dec_valid), 0);
    step();
    chk("c2_dec_valid", 32'(dec_valid), 0);
    step();
    chk("c3_dec_valid", 32'(dec_valid), 1);
    chk("c3_dec_pc", dec_pc, RST_PC);
    run(6);
    chk("flow_acc", 32'(acc_cnt), 8);
    chk("flow_pops", 32'(pop_cnt), 6);

    // Decode stalled: exactly DEPTH requests, then one more per pop
    dec_ready = 1'b0;
    do_reset();
    run(8);
    chk("bp_acc", 32'(acc_cnt), 4);
    chk("bp_req_valid", 32'(imem_req_valid), 0);
    chk("bp_dec_pc", dec_pc, RST_PC);
    dec_ready = 1'b1;
    step();
    dec_ready = 1'b0;
    run(5);
    chk("bp_acc_after_pop", 32'(acc_cnt), 5);
    chk("bp_req_valid2", 32'(imem_req_valid), 0);
    chk("bp_pops", 32'(pop_cnt), 1);

    // Full reservation, pop and late response in the same cycle
    dec_ready = 1'b0;
    do_reset();
    run(3);
    rsp_en = 1'b0;
    step();
    chk("full_req_valid", 32'(imem_req_valid), 0);
    dec_ready = 1'b1;
    rsp_now();
    chk("full_rsp_pop_same", 32'(imem_rsp_valid & dec_valid), 1);
    step();
    dec_ready = 1'b0;
    chk("full_reissue", 32'(imem_req_valid), 1);
    run(3);
    chk("full_req_valid2", 32'(imem_req_valid), 0);
    chk("full_head_pc", dec_pc, RST_PC + 32'd4);
    imem_req_ready = 1'b0;
    dec_ready = 1'b1;
    run(4);
    chk("full_drain_pops", 32'(pop_cnt), 5);
    chk("full_drained", 32'(dec_valid), 0);
    chk("full_addr_hold", imem_req_addr, RST_PC + 32'h14);
    imem_req_ready = 1'b1;

    // Back-to-back redirects with 2 in flight; both responses dropped
    dec_ready = 1'b1;
    do_reset();
    rsp_en = 1'b0;
    run(2);
    chk("rd_outst_full", 32'(imem_req_valid), 0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_5000;
    #1;
    chk("rd_no_req", 32'(imem_req_valid), 0);
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_1002;
    exp_req = 32'h0000_1000;
    exp_pc  = 32'h0000_1000;
    #1;
    step();
    chk("rd_dec_valid", 32'(dec_valid), 0);
    chk("rd_addr", imem_req_addr, 32'h0000_1000);
    rsp_now();
    run(3);
    chk("rd_first_valid", 32'(dec_valid), 1);
    chk("rd_first_pc", dec_pc, 32'h0000_1000);
    run(3);
    chk("rd_pops", 32'(pop_cnt), 3);

    // Redirect during flow (pop and response ignored), then address wrap
    chk("wr_pre_valid", 32'(dec_valid & imem_rsp_valid), 1);
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    exp_req = 32'hFFFF_FFF8;
    exp_pc  = 32'hFFFF_FFF8;
    #1;
    chk("wr_no_req", 32'(imem_req_valid), 0);
    step();
    chk("wr_dec_valid", 32'(dec_valid), 0);
    chk("wr_addr", imem_req_addr, 32'hFFFF_FFF8);
    run(6);
    chk("wr_pops", 32'(pop_cnt), 7);

    // Asynchronous reset with 2 requests in flight and a non-empty queue
    dec_ready = 1'b0;
    do_reset();
    run(2);
    rsp_en = 1'b0;
    run(2);
    chk("ar_pre_valid", 32'(dec_valid), 1);
    chk("ar_pre_pc", dec_pc, RST_PC);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_req_valid", 32'(imem_req_valid), 0);
    chk("ar_req_addr", imem_req_addr, RST_PC);
    chk("ar_dec_valid", 32'(dec_valid), 0);
    chk("ar_dec_instr", dec_instr, 0);
    chk("ar_dec_pc", dec_pc, 0);
    dec_ready = 1'b1;
    do_reset();
    chk("ar_restart_valid", 32'(imem_req_valid), 1);
    chk("ar_restart_addr", imem_req_addr, RST_PC);
    run(5);
    chk("ar_pops", 32'(pop_cnt), 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
